// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
// Holds the default halt encoding, the fetch FSM state encoding and the
// instruction field widths used by the fetch stage and its helpers.
package mips_pkg;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFC00_0000;

  localparam int OPCODE_W = 6;
  localparam int IMM_W    = 16;
  localparam int JIDX_W   = 26;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   pc         current fetch PC (sequential path uses pc + 4)
//   ir_pc      address of the instruction being accepted by decode
//   br_offset  signed word offset of a branch
//   jmp_index  jump target field
//   jmp        jump redirect request (already qualified by the caller)
//   br_taken   branch redirect request (already qualified by the caller)
//   next_pc    jump target, branch target, or pc + 4, in that priority
//   redirect   a jump or branch is being applied
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0]       pc,
  input  logic [31:0]       ir_pc,
  input  logic [IMM_W-1:0]  br_offset,
  input  logic [JIDX_W-1:0] jmp_index,
  input  logic              jmp,
  input  logic              br_taken,
  output logic [31:0]       next_pc,
  output logic              redirect
);

  logic [31:0] ir_pc_plus4;
  logic [31:0] br_disp;
  logic [31:0] br_target;
  logic [31:0] jmp_target;

  assign ir_pc_plus4 = ir_pc + 32'd4;
  // sign-extended word offset scaled to bytes
  assign br_disp     = {{(32-IMM_W-2){br_offset[IMM_W-1]}}, br_offset, 2'b00};
  assign br_target   = ir_pc_plus4 + br_disp;
  assign jmp_target  = {ir_pc_plus4[31:28], jmp_index, 2'b00};

  assign redirect = jmp | br_taken;

  always_comb begin
    next_pc = pc + 32'd4;
    if (jmp) begin
      next_pc = jmp_target;
    end else if (br_taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational instruction
// memory, holds the fetched word in IR for decode, applies redirects and
// stops on a halt word or an out-of-range fetch address.
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   imem_addr, imem_rd   instruction memory address (= PC) and read data
//   ir, ir_pc, ir_valid  instruction, its address and valid flag to decode
//   ir_ready             decode accepts ir this cycle
//   br_taken, br_offset  branch redirect, sampled on accept
//   jmp, jmp_index       jump redirect, sampled on accept, beats branch
//   halted, fault        sticky status (HALT / FAULT state)
//   fetch_count          number of accepted instructions, wraps
//
// state | meaning
// BOOT  | one idle cycle after reset, PC range checked
// RUN   | fetching; loads IR whenever it is empty or being accepted
// HALT  | halt word fetched; PC frozen, pending IR may drain
// FAULT | PC out of range; no fetch, pending IR may drain
module fetch_unit
  import mips_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rd,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [IMM_W-1:0]  br_offset,
  input  logic              jmp,
  input  logic [JIDX_W-1:0] jmp_index,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  fetch_state_t state, state_next;

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        accept;
  logic        load_opp;
  logic        in_range;
  logic        redirect_en;
  logic        redirect;
  logic        do_load;
  logic        clr_valid;

  assign accept      = ir_valid & ir_ready;
  assign load_opp    = (state == RUN) & (~ir_valid | ir_ready);
  assign in_range    = ((pc >> (DEPTH + 2)) == 32'd0) && (pc[1:0] == 2'b00);
  // redirect inputs only matter on an accept while fetching
  assign redirect_en = (state == RUN) & accept;

  next_pc_calc u_next_pc (
    .pc        (pc),
    .ir_pc     (ir_pc),
    .br_offset (br_offset),
    .jmp_index (jmp_index),
    .jmp       (jmp & redirect_en),
    .br_taken  (br_taken & redirect_en),
    .next_pc   (next_pc),
    .redirect  (redirect)
  );

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    clr_valid  = 1'b0;
    case (state)
      BOOT: state_next = in_range ? RUN : FAULT;
      RUN: begin
        if (redirect) begin
          // the word at PC is wrong-path; drop IR and refetch from target
          clr_valid = 1'b1;
        end else if (load_opp) begin
          if (!in_range) begin
            state_next = FAULT;
            clr_valid  = accept;
          end else begin
            do_load = 1'b1;
            if (imem_rd == HALT_WORD) state_next = HALT;
          end
        end
      end
      HALT, FAULT: clr_valid = accept;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= 32'd0;
      ir_pc    <= 32'd0;
      ir_valid <= 1'b0;
    end else if (do_load) begin
      ir       <= imem_rd;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      pc       <= next_pc;
    end else if (clr_valid) begin
      ir_valid <= 1'b0;
      if (redirect) pc <= next_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'd0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign imem_addr = pc;
  assign halted    = (state == HALT);
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = 16'd0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_index = 26'd0;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:255];
  logic [63:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .br_taken    (br_taken),
    .br_offset   (br_offset),
    .jmp         (jmp),
    .jmp_index   (jmp_index),
    .halted      (halted),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  assign imem_rd = mem[imem_addr[9:2]];

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every accept decode will see at the next edge is scored
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && ir_valid && ir_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got ir_pc %h expected no accept", ir_pc);
        end else begin
          e = exp_q.pop_front();
          check32("accept_ir_pc", ir_pc, e[63:32]);
          check32("accept_ir", ir, e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic load_mem(input logic halt_at5);
    for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0000 + 32'(i);
    mem[0] = 32'h2010_000A;
    mem[1] = 32'h2011_0014;
    mem[2] = 32'h0211_9020;
    mem[3] = 32'hAC12_0000;
    if (halt_at5) mem[5] = 32'hFC00_0000;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic do_accept(input int exp_wait, input int stall,
                           input logic b, input logic [15:0] off,
                           input logic j, input logic [25:0] idx,
                           input logic [31:0] epc, input logic [31:0] eword);
    int n = 0;
    exp_q.push_back({epc, eword});
    while (!ir_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    check32("wait_cycles", 32'(n), 32'(exp_wait));
    for (int s = 0; s < stall; s++) begin
      ir_ready = 1'b0;
      @(negedge clk);
      check32("stall_ir_pc", ir_pc, epc);
      check32("stall_ir", ir, eword);
      check32("stall_pc", imem_addr, epc + 32'd4);
      check32("stall_valid", {31'd0, ir_valid}, 32'd1);
    end
    ir_ready  = 1'b1;
    br_taken  = b;
    br_offset = off;
    jmp       = j;
    jmp_index = idx;
    @(negedge clk);
    br_taken = 1'b0;
    jmp      = 1'b0;
  endtask

  task automatic do_reset();
    ir_ready = 1'b0;
    br_taken = 1'b0;
    jmp      = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
  endtask

  initial begin
    // sequential, backpressure, branch, jump priority
    load_mem(1'b0);
    do_reset();
    check32("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check32("rst_pc", imem_addr, 32'h0);
    check32("rst_count", fetch_count, 32'd0);
    check32("rst_status", {30'd0, halted, fault}, 32'd0);
    ir_ready = 1'b1;
    do_accept(2, 0, 0, 16'h0000, 0, 26'd0, 32'h00, 32'h2010_000A);
    do_accept(0, 3, 0, 16'h0000, 0, 26'd0, 32'h04, 32'h2011_0014);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h08, 32'h0211_9020);
    do_accept(0, 0, 1, 16'h0007, 0, 26'd0, 32'h0C, 32'hAC12_0000);
    do_accept(1, 0, 1, 16'hFFF9, 0, 26'd0, 32'h2C, 32'h2400_000B);
    do_accept(1, 0, 0, 16'h0000, 0, 26'd0, 32'h14, 32'h2400_0005);
    do_accept(0, 0, 1, 16'h0007, 1, 26'd3, 32'h18, 32'h2400_0006);
    do_accept(1, 0, 1, 16'hFFFC, 0, 26'd0, 32'h0C, 32'hAC12_0000);
    do_accept(1, 0, 0, 16'h0000, 0, 26'd0, 32'h00, 32'h2010_000A);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h04, 32'h2011_0014);
    check32("count_seq", fetch_count, 32'd10);

    // async reset in the middle of a stall
    ir_ready = 1'b0;
    @(negedge clk);
    check32("pre_rst_ir_pc", ir_pc, 32'h08);
    #3 reset = 1'b1;
    #1;
    check32("async_ir_valid", {31'd0, ir_valid}, 32'd0);
    check32("async_ir", ir, 32'd0);
    check32("async_ir_pc", ir_pc, 32'd0);
    check32("async_pc", imem_addr, 32'd0);
    check32("async_count", fetch_count, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    ir_ready = 1'b1;
    do_accept(1, 0, 0, 16'h0000, 0, 26'd0, 32'h00, 32'h2010_000A);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h04, 32'h2011_0014);
    check32("count_after_rst", fetch_count, 32'd2);

    // halt word at word 5
    load_mem(1'b1);
    do_reset();
    ir_ready = 1'b1;
    do_accept(2, 0, 0, 16'h0000, 0, 26'd0, 32'h00, 32'h2010_000A);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h04, 32'h2011_0014);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h08, 32'h0211_9020);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h0C, 32'hAC12_0000);
    do_accept(0, 0, 0, 16'h0000, 0, 26'd0, 32'h10, 32'h2400_0004);
    check32("halt_flag_loaded", {31'd0, halted}, 32'd1);
    check32("halt_ir_valid", {31'd0, ir_valid}, 32'd1);
    do_accept(0, 0, 0, 16'h0000, 1, 26'd2, 32'h14, 32'hFC00_0000);
    repeat (4) @(negedge clk);
    check32("halt_drained", {31'd0, ir_valid}, 32'd0);
    check32("halt_sticky", {30'd0, halted, fault}, 32'd2);
    check32("halt_count", fetch_count, 32'd6);

    // jump out of range
    load_mem(1'b0);
    do_reset();
    ir_ready = 1'b1;
    do_accept(2, 0, 0, 16'h0000, 1, 26'h100, 32'h00, 32'h2010_000A);
    check32("fault_bubble", {31'd0, ir_valid}, 32'd0);
    @(negedge clk);
    check32("fault_flag", {30'd0, halted, fault}, 32'd1);
    check32("fault_pc", imem_addr, 32'h400);
    repeat (3) @(negedge clk);
    check32("fault_no_fetch", {31'd0, ir_valid}, 32'd0);
    check32("fault_count", fetch_count, 32'd1);

    check32("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory in the MIPS core.
- Owns the program counter and drives the word address into the combinational-read instruction memory.
- Captures the returned word into an instruction register (IR) and hands it to decode over a valid/ready handshake.
- Applies branch/jump redirects from decode, detects halt and out-of-range fetches, and counts retired fetches.

Parameters:
- DEPTH, 8, instruction memory word-address bits (memory holds 2**DEPTH words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFC00_0000, instruction encoding that stops fetching.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals PC.
- imem_rd  input  32  instruction word returned combinationally for imem_addr.
- ir  output  32  registered instruction presented to decode.
- ir_pc  output  32  byte address of the instruction in ir.
- ir_valid  output  1  ir/ir_pc hold a valid instruction.
- ir_ready  input  1  decode accepts ir this cycle.
- br_taken  input  1  branch redirect; sampled only on an accept.
- br_offset  input  16  signed word offset of the branch.
- jmp  input  1  jump redirect; sampled only on an accept; jmp has priority over br_taken.
- jmp_index  input  26  jump target field.
- halted  output  1  sticky; HALT state.
- fault  output  1  sticky; FAULT state.
- fetch_count  output  32  number of accepted instructions.

Behaviour:
- Reset (async, any state, including mid-operation):
  - PC = RESET_PC, ir = 0, ir_pc = 0, ir_valid = 0, halted = 0, fault = 0, fetch_count = 0, state = BOOT.
- accept = ir_valid & ir_ready.
- load = state==RUN & (!ir_valid | ir_ready).
- Range check: PC is in range iff PC[31:DEPTH+2] == 0 and PC[1:0] == 0.
- FSM states: BOOT, RUN, HALT, FAULT.
- BOOT: one cycle with no fetch. Go to RUN, unless PC is out of range, in which case go to FAULT.
- RUN, redirect case (accept & (jmp | br_taken)):
  - ir_valid <= 0; the word at PC is wrong-path and is discarded.
  - PC <= target.
  - Exactly one bubble: the target instruction appears in ir two edges after the accepting edge.
- RUN, normal load (load, no redirect):
  - ir <= imem_rd, ir_pc <= PC, ir_valid <= 1, PC <= PC + 4 (mod 2**32).
- RUN, stall (ir_valid & !ir_ready): PC, ir, ir_pc and ir_valid hold.
- RUN, idle consume (accept without load, not possible with the load rule above): ir_valid <= 0.
- Redirect targets:
  - Branch target = ir_pc + 4 + (sign_extend(br_offset) << 2), 32-bit, wraps.
  - Jump target = {ir_pc_plus4[31:28], jmp_index, 2'b00}.
- Halt: when a load captures imem_rd == HALT_WORD:
  - The halt word is still presented in ir with ir_valid = 1.
  - State goes to HALT and PC is frozen.
  - In HALT: the existing ir may still be accepted once, after which ir_valid = 0.
  - Redirects are ignored in HALT. halted = 1.
- Fault: PC out of range in RUN at a load opportunity (including immediately after a redirect):
  - No load happens; state goes to FAULT; fault = 1.
  - A pending ir may still drain, as in HALT.
- HALT and FAULT are left only by reset.
- fetch_count increments by 1 on every accept, wraps at 2**32, and counts in all states.
- Simultaneous jmp & br_taken: the jump target is used.

Decomposition:
- Shared package mips_pkg holds:
  - HALT_WORD default.
  - Fetch state enum (BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2, FAULT = 2'd3).
  - Opcode/field width constants: OPCODE 6, IMM 16, JIDX 26.
- One sub-module, next_pc_calc: purely combinational. It takes pc, ir_pc, br_offset, jmp_index, jmp and br_taken, and returns next_pc and redirect.
- FSM, IR and counter stay in fetch_unit.

Test Plan:
- Sequential fetch: imem words 0..3 = 2010000A, 20110014, 02119020, AC120000, ir_ready = 1 throughout. Required: ir_pc = 0, 4, 8, C on consecutive cycles after BOOT; fetch_count = 4.
- Backpressure: ir_ready = 0 for 3 cycles while ir_pc = 4. Required: ir, ir_pc and PC hold; no word is skipped or repeated once ir_ready returns to 1.
- Branch redirect: accept at ir_pc = 0xC with br_taken = 1, br_offset = 16'h0007. Required: one cycle with ir_valid = 0, then ir_pc = 0x2C. A second case with br_offset = 16'hFFFC gives ir_pc = 0x0.
- Jump priority: accept at ir_pc = 0x18 with jmp = 1, jmp_index = 3 and br_taken = 1. Required: next ir_pc = 0xC.
- Halt / fault:
  - HALT_WORD at word 5: halted = 1 after it loads; ir_pc = 0x14 is accepted once, then ir_valid stays 0.
  - Jump to index 2**DEPTH (0x400 with DEPTH = 8): fault = 1, no further fetch.
- Async reset mid-stall (reset pulse between clock edges): all outputs clear immediately; fetch restarts from RESET_PC after BOOT.
